pipe_carry_adder: RTL and testbench



---
 rtl/pipe_carry_adder_pkg.sv | 12 +
 rtl/add_seg.sv | 26 ++
 rtl/pipe_carry_adder.sv | 127 ++++++++++++
 tb/tb_pipe_carry_adder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_carry_adder_pkg.sv
// Shared defaults and parameter helpers for the segmented, pipelined carry adder.
package pipe_carry_adder_pkg;

  localparam int unsigned DefaultWidth = 8;
  localparam int unsigned DefaultSegW  = 4;

  // Number of ripple segments, which is also the pipeline depth.
  function automatic int unsigned num_segs(input int unsigned width, input int unsigned seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/add_seg.sv
// Combinational SEG_W-bit ripple-carry adder: one pipeline stage's worth of carry chain.
module add_seg #(
  parameter int unsigned SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_s,
  input  logic [SEG_W-1:0] b_s,
  input  logic             c_i,
  output logic [SEG_W-1:0] s_s,
  output logic             c_o
);

  logic [SEG_W:0] c;

  always_comb begin
    c    = '0;
    s_s  = '0;
    c[0] = c_i;
    for (int i = 0; i < SEG_W; i++) begin
      s_s[i]   = a_s[i] ^ b_s[i] ^ c[i];
      c[i+1]   = (a_s[i] & b_s[i]) | (c[i] & (a_s[i] ^ b_s[i]));
    end
  end

  assign c_o = c[SEG_W];

endmodule

// File: rtl/pipe_carry_adder.sv
// Pipelined WIDTH-bit add/subtract: one SEG_W-bit ripple segment per stage, carry registered
// between stages, operands skewed forward and finished sum segments carried along.
module pipe_carry_adder
  import pipe_carry_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned SEG_W = DefaultSegW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NSEG = num_segs(WIDTH, SEG_W);
  localparam int unsigned Last = NSEG - 1;

  if ((WIDTH % SEG_W) != 0 || WIDTH < SEG_W) begin : g_bad_params
    $error("pipe_carry_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic             adv;
  logic             accept;

  logic [NSEG-1:0]  valid_q;
  logic [NSEG-1:0]  carry_q;
  logic [NSEG-1:0]  sub_q;
  logic [WIDTH-1:0] a_q   [NSEG];
  logic [WIDTH-1:0] b_q   [NSEG];
  logic [WIDTH-1:0] sum_q [NSEG];

  // Per-stage inputs: the port values for stage 0, the previous stage register otherwise.
  logic [NSEG-1:0]  valid_src;
  logic [NSEG-1:0]  carry_src;
  logic [NSEG-1:0]  sub_src;
  logic [WIDTH-1:0] a_src   [NSEG];
  logic [WIDTH-1:0] b_src   [NSEG];
  logic [WIDTH-1:0] sum_src [NSEG];

  logic [NSEG-1:0]  carry_d;
  logic [WIDTH-1:0] sum_d [NSEG];

  // The whole pipe moves as one; bubbles are never squeezed out.
  assign adv      = !valid_q[Last] || out_ready;
  assign in_ready = adv && !rst;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [SEG_W-1:0] b_eff;
    logic [SEG_W-1:0] seg_sum;
    logic [WIDTH-1:0] sum_nxt;

    if (k == 0) begin : g_head
      assign valid_src[k] = accept;
      assign carry_src[k] = cin ^ sub;
      assign sub_src[k]   = sub;
      assign a_src[k]     = a;
      assign b_src[k]     = b;
      assign sum_src[k]   = '0;
    end else begin : g_body
      assign valid_src[k] = valid_q[k-1];
      assign carry_src[k] = carry_q[k-1];
      assign sub_src[k]   = sub_q[k-1];
      assign a_src[k]     = a_q[k-1];
      assign b_src[k]     = b_q[k-1];
      assign sum_src[k]   = sum_q[k-1];
    end

    assign b_eff = b_src[k][k*SEG_W +: SEG_W] ^ {SEG_W{sub_src[k]}};

    add_seg #(
      .SEG_W(SEG_W)
    ) u_add_seg (
      .a_s(a_src[k][k*SEG_W +: SEG_W]),
      .b_s(b_eff),
      .c_i(carry_src[k]),
      .s_s(seg_sum),
      .c_o(carry_d[k])
    );

    always_comb begin
      sum_nxt                   = sum_src[k];
      sum_nxt[k*SEG_W +: SEG_W] = seg_sum;
    end

    assign sum_d[k] = sum_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      sub_q   <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      valid_q <= valid_src;
      carry_q <= carry_d;
      sub_q   <= sub_src;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k]   <= a_src[k];
        b_q[k]   <= b_src[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign out_valid = valid_q[Last];
  assign sum       = sum_q[Last];
  assign cout      = carry_q[Last];
  // Overflow from the last stage's registered operands, so it holds with the sum under stall.
  assign ovf       = (a_q[Last][WIDTH-1] == (b_q[Last][WIDTH-1] ^ sub_q[Last])) &&
                     (sum_q[Last][WIDTH-1] != a_q[Last][WIDTH-1]);

endmodule

// File: tb/tb_pipe_carry_adder.sv
// Directed bench for pipe_carry_adder at 8/4 (two stages) and 8/8 (single stage).
module tb_pipe_carry_adder;

  localparam int NVEC = 16384;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a, b;
  logic       cin, sub;

  logic       iv4, ir4, ov4, or4, cout4, ovf4;
  logic [7:0] sum4;
  logic       iv8, ir8, ov8, or8, cout8, ovf8;
  logic [7:0] sum8;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] st_a [5];
  logic [7:0] st_b [5];
  logic [7:0] st_s [5];

  always #5 clk = ~clk;

  pipe_carry_adder #(.WIDTH(8), .SEG_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(or4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  pipe_carry_adder #(.WIDTH(8), .SEG_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(ov8), .out_ready(or8), .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer arithmetic, unsigned for carry and signed for overflow.
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic cv, input logic sv);
    int ua, ub, sa, sb, ci, u, s;
    logic c, o;
    logic [7:0] r;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ci = int'(cv);
    if (sv) begin
      u = ua - ub - ci;
      s = sa - sb - ci;
      c = (u >= 0);
    end else begin
      u = ua + ub + ci;
      s = sa + sb + ci;
      c = (u > 255);
    end
    o = (s > 127) || (s < -128);
    r = u[7:0];
    return {o, c, r};
  endfunction

  // One beat through the two-stage DUT with hand-computed results and exact latency.
  task automatic beat4(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic sv, input logic [7:0] es,
                       input logic ec, input logic eo);
    a = av; b = bv; cin = cv; sub = sv; iv4 = 1'b1; or4 = 1'b1;
    #1;
    chk({tag, "_in_ready"}, ir4, 1);
    tick();
    iv4 = 1'b0;
    chk({tag, "_lat1"}, ov4, 0);
    tick();
    chk({tag, "_valid"}, ov4, 1);
    chk({tag, "_sum"}, sum4, es);
    chk({tag, "_cout"}, cout4, ec);
    chk({tag, "_ovf"}, ovf4, eo);
    tick();
    chk({tag, "_drain"}, ov4, 0);
  endtask

  // Stream NVEC vectors through one DUT under random output throttling.
  task automatic sweep(input bit sel, input string tag);
    logic [9:0]  q[$];
    logic [9:0]  exp;
    logic [9:0]  obs;
    logic [13:0] nv;
    int n, nret;
    n = 0;
    nret = 0;
    for (int cyc = 0; cyc < 30000 && nret < NVEC; cyc++) begin
      nv = n[13:0];
      a  = nv[7:0];
      b  = {nv[13:8], nv[7:6]};
      {sub, cin} = nv[9:8] ^ nv[3:2];
      if (sel) begin
        iv8 = (n < NVEC);
        or8 = ($urandom_range(3) != 0);
      end else begin
        iv4 = (n < NVEC);
        or4 = ($urandom_range(3) != 0);
      end
      #1;
      if (sel ? (ov8 && or8) : (ov4 && or4)) begin
        obs = sel ? {ovf8, cout8, sum8} : {ovf4, cout4, sum4};
        exp = (q.size() > 0) ? q.pop_front() : 10'bx;
        chk(tag, obs, exp);
        nret++;
      end
      if (sel ? (iv8 && ir8) : (iv4 && ir4)) begin
        q.push_back(model(a, b, cin, sub));
        n++;
      end
      tick();
    end
    iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
    chk({tag, "_count"}, nret, NVEC);
  endtask

  initial begin
    int idx_in, idx_out, stall_cnt;

    st_a = '{8'h01, 8'h10, 8'hFF, 8'h80, 8'h3C};
    st_b = '{8'h02, 8'h20, 8'hFF, 8'h80, 8'hC4};
    st_s = '{8'h03, 8'h30, 8'hFE, 8'h00, 8'h00};

    rst = 1'b1; iv4 = 1'b0; iv8 = 1'b0; or4 = 1'b1; or8 = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk("rst_valid", ov4, 0);
    chk("rst_sum", sum4, 0);
    chk("rst_cout", cout4, 0);
    chk("rst_ovf", ovf4, 0);
    chk("rst_in_ready", ir4, 0);
    chk("rst_valid8", ov8, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", ir4, 1);

    beat4("add_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    beat4("add_wrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    beat4("add_cin",  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    beat4("sub_neg",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    beat4("sub_ovf",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back stream; out_ready dropped for three cycles after the first result.
    idx_in = 0; idx_out = 0; stall_cnt = 0; cin = 1'b0; sub = 1'b0;
    for (int cyc = 0; cyc < 30 && idx_out < 5; cyc++) begin
      iv4 = (idx_in < 5);
      if (idx_in < 5) begin
        a = st_a[idx_in];
        b = st_b[idx_in];
      end
      or4 = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      #1;
      if (ov4 && !or4) begin
        chk("stall_in_ready", ir4, 0);
        chk("stall_hold", sum4, st_s[idx_out]);
      end
      if (ov4 && or4) begin
        chk("stream_order", sum4, st_s[idx_out]);
        idx_out++;
        if (idx_out == 1) stall_cnt = 3;
      end
      if (iv4 && ir4) idx_in++;
      tick();
    end
    iv4 = 1'b0; or4 = 1'b1;
    chk("stream_count", idx_out, 5);
    chk("stream_nodup0", ov4, 0);
    tick();
    chk("stream_nodup1", ov4, 0);

    // Two beats in flight, then reset: neither may ever leave the block.
    or4 = 1'b0;
    a = 8'h01; b = 8'h01; iv4 = 1'b1;
    tick();
    a = 8'h02; b = 8'h02;
    tick();
    iv4 = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_valid", ov4, 0);
    chk("midrst_sum", sum4, 0);
    chk("midrst_cout", cout4, 0);
    chk("midrst_ovf", ovf4, 0);
    or4 = 1'b1;
    #1;
    chk("midrst_in_ready", ir4, 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_ghost", ov4, 0);
    end
    beat4("post_midrst", 8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);

    sweep(1'b0, "sweep_w8s4");
    sweep(1'b1, "sweep_w8s8");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
